// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for the dual-port FIFO: read pointer, write-pointer sync, empty flag, output stream.
// Optional almost-empty flag (raempty) is built only when FIFO_RD_AEMPTY_EN is defined.
module fifo_rd_ctrl #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4
`ifdef FIFO_RD_AEMPTY_EN
    ,
    parameter int AEMPTY_THRESH = 2
`endif
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic [ADDRSIZE:0]   wptr_gray,
    input  logic [DATASIZE-1:0] rdata_mem,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic [ADDRSIZE:0]   rlevel,
    output logic [DATASIZE-1:0] m_data,
    output logic                m_valid,
    input  logic                m_ready
`ifdef FIFO_RD_AEMPTY_EN
    ,
    output logic                raempty
`endif
);

    // Stream handshake: a beat transfers on a rising edge where m_valid && m_ready.
    // m_data/m_valid are registered; m_data holds while m_valid && !m_ready.

    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] rq1;
    logic [ADDRSIZE:0] rq2_wptr;
    logic [ADDRSIZE:0] rbinnext;
    logic [ADDRSIZE:0] rgraynext;
    logic [ADDRSIZE:0] wbin_sync;
    logic              pop;

    function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
        logic [ADDRSIZE:0] b;
        b[ADDRSIZE] = g[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    always_comb begin
        pop       = !rempty && (!m_valid || m_ready);
        rbinnext  = rbin + {{ADDRSIZE{1'b0}}, pop};
        rgraynext = (rbinnext >> 1) ^ rbinnext;
        wbin_sync = gray2bin(rq2_wptr);
    end

    // The stalled word already left memory, so it is not counted here.
    assign rlevel = wbin_sync - rbin;
    assign raddr  = rbin[ADDRSIZE-1:0];

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            rq1      <= '0;
            rq2_wptr <= '0;
            rbin     <= '0;
            rptr     <= '0;
            rempty   <= 1'b1;
            m_valid  <= 1'b0;
            m_data   <= '0;
        end else begin
            rq1      <= wptr_gray;
            rq2_wptr <= rq1;
            rbin     <= rbinnext;
            rptr     <= rgraynext;
            // Compared against the lagging synced pointer, so empty can only be late, never early.
            rempty   <= (rgraynext == rq2_wptr);
            if (pop) begin
                m_data  <= rdata_mem;
                m_valid <= 1'b1;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

`ifdef FIFO_RD_AEMPTY_EN
    localparam logic [ADDRSIZE:0] AEMPTY_LVL = AEMPTY_THRESH[ADDRSIZE:0];

    logic [ADDRSIZE:0] level_next;

    assign level_next = wbin_sync - rbinnext;

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            raempty <= 1'b1;
        end else begin
            raempty <= (level_next <= AEMPTY_LVL);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: a table of per-cycle vectors plus directed multi-cycle sequences.
// Models fifomem and the write-side pointer; checks the stream against an expected queue.
module tb_fifo_rd_ctrl;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          rclk = 1'b0;
    logic          rrst_n = 1'b0;
    logic [AW:0]   wptr_gray = '0;
    logic [DW-1:0] rdata_mem;
    logic [AW-1:0] raddr;
    logic [AW:0]   rptr;
    logic          rempty;
    logic [AW:0]   rlevel;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
`ifdef FIFO_RD_AEMPTY_EN
    logic          raempty;
`endif

    logic [DW-1:0] mem [DEPTH];
    assign rdata_mem = mem[raddr];

    always #5 rclk = ~rclk;

    fifo_rd_ctrl #(
        .DATASIZE(DW),
        .ADDRSIZE(AW)
`ifdef FIFO_RD_AEMPTY_EN
        ,
        .AEMPTY_THRESH(2)
`endif
    ) dut (
        .rclk(rclk),
        .rrst_n(rrst_n),
        .wptr_gray(wptr_gray),
        .rdata_mem(rdata_mem),
        .raddr(raddr),
        .rptr(rptr),
        .rempty(rempty),
        .rlevel(rlevel),
        .m_data(m_data),
        .m_valid(m_valid),
        .m_ready(m_ready)
`ifdef FIFO_RD_AEMPTY_EN
        ,
        .raempty(raempty)
`endif
    );

    int            n_cmp = 0;
    int            n_err = 0;
    int            rx_count = 0;
    logic [DW-1:0] exp_q[$];
    logic [AW:0]   wbin = '0;
    bit            sb_en = 1'b0;
    bit            wrote = 1'b0;

    function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [AW:0] g2b(input logic [AW:0] g);
        logic [AW:0] b;
        b = '0;
        for (int i = AW; i >= 0; i--) begin
            b[i] = ((i == AW) ? 1'b0 : b[i+1]) ^ g[i];
        end
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive at the falling edge, score the beat about to transfer, sample 1 after the rise.
    task automatic cycle(input logic rst_v, input logic push, input logic [DW-1:0] wd, input logic ready);
        logic [AW:0] used;
        @(negedge rclk);
        rrst_n  = rst_v;
        m_ready = ready;
        wrote   = 1'b0;
        if (!rst_v) begin
            wbin      = '0;
            wptr_gray = '0;
            exp_q.delete();
        end else begin
            if (sb_en && m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_extra_beat", 32'(m_data), 32'hFFFF_FFFF);
                end else begin
                    chk("sb_data", 32'(m_data), 32'(exp_q.pop_front()));
                    rx_count++;
                end
            end
            used = wbin - g2b(rptr);
            if (push && !used[AW]) begin
                mem[wbin[AW-1:0]] = wd;
                exp_q.push_back(wd);
                wbin      = wbin + 1'b1;
                wptr_gray = bin2gray(wbin);
                wrote     = 1'b1;
            end
        end
        @(posedge rclk);
        #1;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0);
        rx_count = 0;
    endtask

    typedef struct {
        logic          rst;
        logic          push;
        logic [DW-1:0] wd;
        logic          ready;
        logic          e_rempty;
        logic          e_valid;
        logic [DW-1:0] e_data;
        logic [AW-1:0] e_raddr;
        logic [AW:0]   e_rptr;
        logic [AW:0]   e_level;
    } vec_t;

    vec_t vecs [15];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        int          sent;
        bit          seen_wrap;
        logic [AW:0] prev_rptr;

        for (int i = 0; i < DEPTH; i++) mem[i] = '0;

        // rst push wd ready | rempty valid data raddr rptr level
        vecs[0]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 5'd0, 5'd0};
        vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 5'd0, 5'd0};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 5'd0, 5'd0};
        vecs[3]  = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 5'd0, 5'd0};
        vecs[4]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 5'd0, 5'd1};
        vecs[5]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 5'd0, 5'd1};
        vecs[6]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 4'd1, 5'd1, 5'd0};
        vecs[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA5, 4'd1, 5'd1, 5'd0};
        vecs[8]  = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'hA5, 4'd1, 5'd1, 5'd0};
        vecs[9]  = '{1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'hA5, 4'd1, 5'd1, 5'd1};
        vecs[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 4'd1, 5'd1, 5'd2};
        vecs[11] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 4'd2, 5'd3, 5'd1};
        vecs[12] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 4'd2, 5'd3, 5'd1};
        vecs[13] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 4'd3, 5'd2, 5'd0};
        vecs[14] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h22, 4'd3, 5'd2, 5'd0};

        // Reset, single word, short backpressure
        for (int i = 0; i < 15; i++) begin
            cycle(vecs[i].rst, vecs[i].push, vecs[i].wd, vecs[i].ready);
            chk($sformatf("v%0d_rempty", i), 32'(rempty), 32'(vecs[i].e_rempty));
            chk($sformatf("v%0d_m_valid", i), 32'(m_valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d_m_data", i), 32'(m_data), 32'(vecs[i].e_data));
            chk($sformatf("v%0d_raddr", i), 32'(raddr), 32'(vecs[i].e_raddr));
            chk($sformatf("v%0d_rptr", i), 32'(rptr), 32'(vecs[i].e_rptr));
            chk($sformatf("v%0d_rlevel", i), 32'(rlevel), 32'(vecs[i].e_level));
        end

        // Backpressure: full memory, one word parked in the output register
        sb_en = 1'b1;
        do_reset(3);
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, DW'(8'h30 + i), 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'h00, 1'b0);
        chk("bp_raddr", 32'(raddr), 32'd1);
        chk("bp_rlevel", 32'(rlevel), 32'd15);
        chk("bp_m_valid", 32'(m_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 8'h00, 1'b0);
            chk("bp_m_data_hold", 32'(m_data), 32'h30);
        end
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 40) begin
            cycle(1'b1, 1'b0, 8'h00, 1'b1);
            cyc++;
        end
        chk("bp_beat_cycles", 32'(cyc), 32'd16);
        chk("bp_rx_count", 32'(rx_count), 32'd16);
        chk("bp_end_valid", 32'(m_valid), 32'd0);
        chk("bp_end_rempty", 32'(rempty), 32'd1);

        // Pointer wrap: 40 words with random downstream readiness
        do_reset(2);
        sent = 0;
        seen_wrap = 1'b0;
        prev_rptr = rptr;
        for (int c = 0; c < 3000 && rx_count < 40; c++) begin
            cycle(1'b1, 1'(sent < 40), DW'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            if (wrote) sent++;
            if (prev_rptr == 5'd16 && rptr == 5'd0) seen_wrap = 1'b1;
            prev_rptr = rptr;
        end
        chk("wrap_rx_count", 32'(rx_count), 32'd40);
        chk("wrap_seen_31_to_0", 32'(seen_wrap), 32'd1);
        chk("wrap_queue_left", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);
        chk("wrap_rempty", 32'(rempty), 32'd1);
        chk("wrap_m_valid", 32'(m_valid), 32'd0);
        chk("wrap_rlevel", 32'(rlevel), 32'd0);
        chk("wrap_rptr", 32'(rptr), 32'h0C);

        // Reset while a word is stalled and five remain
        do_reset(2);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, DW'(8'h50 + i), 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'h00, 1'b0);
        chk("mr_pre_valid", 32'(m_valid), 32'd1);
        chk("mr_pre_rlevel", 32'(rlevel), 32'd5);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        chk("mr_m_valid", 32'(m_valid), 32'd0);
        chk("mr_rptr", 32'(rptr), 32'd0);
        chk("mr_rempty", 32'(rempty), 32'd1);
        chk("mr_m_data", 32'(m_data), 32'd0);
        chk("mr_raddr", 32'(raddr), 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h00, 1'b0);
        chk("mr_post_rempty", 32'(rempty), 32'd1);
        chk("mr_post_rlevel", 32'(rlevel), 32'd0);
        chk("mr_post_valid", 32'(m_valid), 32'd0);

`ifdef FIFO_RD_AEMPTY_EN
        // Almost-empty threshold of 2
        do_reset(2);
        chk("ae_reset", 32'(raempty), 32'd1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, DW'(8'h70 + i), 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'h00, 1'b0);
        chk("ae_lvl3_rlevel", 32'(rlevel), 32'd3);
        chk("ae_lvl3_raempty", 32'(raempty), 32'd0);
        cycle(1'b1, 1'b0, 8'h00, 1'b1);
        chk("ae_lvl2_rlevel", 32'(rlevel), 32'd2);
        chk("ae_lvl2_raempty", 32'(raempty), 32'd1);
        chk("ae_lvl2_m_data", 32'(m_data), 32'h71);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
